// File: rtl/video_frame_sched.sv
// Frame-level capture scheduler: arms on vsync when a DMA buffer is free, gates capture,
// rotates ring buffer indices on DMA completion and reports drops, short frames and timeouts.
module video_frame_sched #(
    parameter int unsigned VIDEO_CLK_FREQ = 148500000,
    parameter int unsigned IMG_HEIGHT     = 1080,
    parameter int unsigned NUM_BUF        = 4,
    localparam int unsigned BUF_W         = $clog2(NUM_BUF)
) (
    input  logic             i_video_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [15:0]      i_frame_num,
    input  logic             i_video_vs,
    input  logic             i_video_de,
    input  logic             i_buf_ready,
    input  logic             i_dma_done,
    output logic             o_capture_en,
    output logic             o_frame_start,
    output logic             o_frame_done,
    output logic             o_seq_done,
    output logic             o_busy,
    output logic [BUF_W-1:0] o_buf_idx,
    output logic [31:0]      o_frame_cnt,
    output logic [15:0]      o_drop_cnt,
    output logic             o_frame_err,
    output logic             o_timeout
);

    localparam int unsigned TIME_OUT = VIDEO_CLK_FREQ;
    localparam int unsigned DLY_W    = $clog2(TIME_OUT + 1);
    localparam int unsigned LINE_W   = ($clog2(IMG_HEIGHT) > 11) ? $clog2(IMG_HEIGHT) : 11;

    typedef enum logic [1:0] {StIdle, StArm, StCapture, StWaitDone} state_e;

    state_e             state_q, state_d;
    logic               vs_d0, de_d0;
    logic [15:0]        frames_left_q, frames_left_d;
    logic               cont_q, cont_d;
    logic               stop_pend_q, stop_pend_d;
    logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
    logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic [BUF_W-1:0]   buf_idx_q, buf_idx_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               timeout_q, timeout_d;
    logic               capture_en_q, busy_q;
    logic               frame_start_q, frame_start_d;
    logic               frame_done_q, frame_done_d;
    logic               seq_done_q, seq_done_d;
    logic               frame_err_q, frame_err_d;

    logic vs_rise, line_end, last_line, dly_expired;

    assign vs_rise     = i_video_vs & ~vs_d0;
    assign line_end    = de_d0 & ~i_video_de;
    assign last_line   = line_end && (line_cnt_q == LINE_W'(IMG_HEIGHT - 1));
    assign dly_expired = (state_q != StIdle) && (dly_cnt_q == DLY_W'(TIME_OUT));

    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        cont_d        = cont_q;
        stop_pend_d   = stop_pend_q;
        line_cnt_d    = line_cnt_q;
        buf_idx_d     = buf_idx_q;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        timeout_d     = timeout_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        seq_done_d    = 1'b0;
        frame_err_d   = 1'b0;
        if (dly_expired) begin
            // Timeout overrides whatever else the current state would have done.
            state_d    = StIdle;
            timeout_d  = 1'b1;
            seq_done_d = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start && !i_stop) begin
                        state_d       = StArm;
                        frames_left_d = i_frame_num;
                        cont_d        = (i_frame_num == 16'd0);
                        frame_cnt_d   = '0;
                        drop_cnt_d    = '0;
                        timeout_d     = 1'b0;
                        stop_pend_d   = 1'b0;
                        buf_idx_d     = '0;
                    end
                end
                StArm: begin
                    if (i_stop) begin
                        state_d    = StIdle;
                        seq_done_d = 1'b1;
                    end else if (vs_rise) begin
                        if (i_buf_ready) begin
                            state_d       = StCapture;
                            frame_start_d = 1'b1;
                            line_cnt_d    = '0;
                        end else if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end
                end
                StCapture: begin
                    if (i_stop) stop_pend_d = 1'b1;
                    if (last_line) begin
                        state_d = StWaitDone;
                    end else if (vs_rise) begin
                        // Short frame: drop it and re-arm on a later vsync.
                        state_d     = StArm;
                        frame_err_d = 1'b1;
                    end else if (line_end) begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (i_stop) stop_pend_d = 1'b1;
                    if (i_dma_done) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 32'd1;
                        buf_idx_d    = buf_idx_q + 1'b1;
                        if (!cont_q) frames_left_d = frames_left_q - 16'd1;
                        if (stop_pend_q || i_stop || (!cont_q && frames_left_q == 16'd1)) begin
                            state_d    = StIdle;
                            seq_done_d = 1'b1;
                        end else begin
                            state_d = StArm;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        dly_cnt_d = dly_cnt_q;
        if (vs_rise || i_video_de || i_dma_done || (state_d != state_q)) begin
            dly_cnt_d = '0;
        end else if (dly_cnt_q != DLY_W'(TIME_OUT)) begin
            dly_cnt_d = dly_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_video_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            vs_d0         <= 1'b0;
            de_d0         <= 1'b0;
            frames_left_q <= '0;
            cont_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            line_cnt_q    <= '0;
            dly_cnt_q     <= '0;
            buf_idx_q     <= '0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            capture_en_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            seq_done_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_d0         <= i_video_vs;
            de_d0         <= i_video_de;
            frames_left_q <= frames_left_d;
            cont_q        <= cont_d;
            stop_pend_q   <= stop_pend_d;
            line_cnt_q    <= line_cnt_d;
            dly_cnt_q     <= dly_cnt_d;
            buf_idx_q     <= buf_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            timeout_q     <= timeout_d;
            capture_en_q  <= (state_d == StCapture);
            busy_q        <= (state_d != StIdle);
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            seq_done_q    <= seq_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign o_capture_en  = capture_en_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_done  = frame_done_q;
    assign o_seq_done    = seq_done_q;
    assign o_busy        = busy_q;
    assign o_buf_idx     = buf_idx_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_frame_err   = frame_err_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_video_frame_sched.sv
// Bench for video_frame_sched: expected pulse events (with buffer index and frame count)
// are queued as stimulus is driven and checked by a monitor as the DUT emits them.
module tb_video_frame_sched;

    localparam int unsigned FREQ = 100;
    localparam int unsigned HGT  = 4;
    localparam int unsigned NBUF = 4;

    localparam int KStart = 0;
    localparam int KErr   = 1;
    localparam int KDone  = 2;
    localparam int KSeq   = 3;

    logic        clk, rst_n;
    logic        start, stop, vs, de, buf_ready, dma_done;
    logic [15:0] frame_num;
    logic        capture_en, frame_start, frame_done, seq_done, busy, frame_err, timeout;
    logic [1:0]  buf_idx;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;

    typedef struct {
        int kind;
        int idx;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    int  vectors;
    int  miscompares;

    video_frame_sched #(
        .VIDEO_CLK_FREQ(FREQ),
        .IMG_HEIGHT    (HGT),
        .NUM_BUF       (NBUF)
    ) dut (
        .i_video_clk  (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_frame_num  (frame_num),
        .i_video_vs   (vs),
        .i_video_de   (de),
        .i_buf_ready  (buf_ready),
        .i_dma_done   (dma_done),
        .o_capture_en (capture_en),
        .o_frame_start(frame_start),
        .o_frame_done (frame_done),
        .o_seq_done   (seq_done),
        .o_busy       (busy),
        .o_buf_idx    (buf_idx),
        .o_frame_cnt  (frame_cnt),
        .o_drop_cnt   (drop_cnt),
        .o_frame_err  (frame_err),
        .o_timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] p;
            p = {seq_done, frame_done, frame_err, frame_start};
            for (int k = 0; k < 4; k++) begin
                if (p[k]) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_pulse: kind %0d seen, none expected (t=%0t)", k, $time);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        if (e.kind !== k || e.idx !== int'(buf_idx) || e.cnt !== int'(frame_cnt)) begin
                            miscompares++;
                            $display("FAIL event: got kind %0d idx %0d cnt %0d, expected kind %0d idx %0d cnt %0d (t=%0t)",
                                     k, buf_idx, frame_cnt, e.kind, e.idx, e.cnt, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int kind, input int idx, input int cnt);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic vsync();
        vs = 1'b1;
        tick(2);
        vs = 1'b0;
        tick(1);
    endtask

    task automatic line();
        de = 1'b1;
        tick(3);
        de = 1'b0;
        tick(2);
    endtask

    task automatic pulse_start(input logic [15:0] n);
        frame_num = n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic dma_pulse();
        dma_done = 1'b1;
        tick(1);
        dma_done = 1'b0;
        tick(2);
    endtask

    task automatic drain_check(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending: %0d expected events never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({capture_en, frame_start, frame_done, seq_done, busy, frame_err, timeout} !== 7'b0
            || buf_idx !== 2'd0 || frame_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: outputs not all zero (busy %b cap %b cnt %0d drop %0d)",
                     busy, capture_en, frame_cnt, drop_cnt);
        end
    endtask

    task automatic test_single_frame();
        pulse_start(16'd1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy: got %b, required 1", busy);
        end
        push_exp(KStart, 0, 0);
        vs = 1'b1;
        tick(1);
        vectors++;
        if (capture_en !== 1'b1) begin
            miscompares++;
            $display("FAIL single_capture_rise: got %b, required 1", capture_en);
        end
        tick(1);
        vs = 1'b0;
        tick(1);
        for (int l = 0; l < 3; l++) line();
        vectors++;
        if (capture_en !== 1'b1) begin
            miscompares++;
            $display("FAIL single_capture_hold: got %b after 3 lines, required 1", capture_en);
        end
        line();
        vectors++;
        if (capture_en !== 1'b0) begin
            miscompares++;
            $display("FAIL single_capture_fall: got %b after 4 lines, required 0", capture_en);
        end
        push_exp(KDone, 1, 1);
        push_exp(KSeq, 1, 1);
        dma_pulse();
        vectors++;
        if (frame_cnt !== 32'd1 || buf_idx !== 2'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_final: cnt %0d idx %0d busy %b, required 1 1 0", frame_cnt, buf_idx, busy);
        end
        drain_check("single");
    endtask

    task automatic test_starvation();
        buf_ready = 1'b0;
        pulse_start(16'd1);
        for (int v = 0; v < 3; v++) vsync();
        vectors++;
        if (drop_cnt !== 16'd3 || capture_en !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_drops: drop %0d cap %b, required 3 0", drop_cnt, capture_en);
        end
        buf_ready = 1'b1;
        push_exp(KStart, 0, 0);
        vsync();
        for (int l = 0; l < 4; l++) line();
        push_exp(KDone, 1, 1);
        push_exp(KSeq, 1, 1);
        dma_pulse();
        vectors++;
        if (drop_cnt !== 16'd3 || frame_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL starve_final: drop %0d cnt %0d, required 3 1", drop_cnt, frame_cnt);
        end
        drain_check("starve");
    endtask

    task automatic test_deferred_stop();
        pulse_start(16'd0);
        push_exp(KStart, 0, 0);
        vsync();
        line();
        line();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        vectors++;
        if (capture_en !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_still_capturing: got %b, required 1", capture_en);
        end
        line();
        line();
        push_exp(KDone, 1, 1);
        push_exp(KSeq, 1, 1);
        dma_pulse();
        vsync();
        vectors++;
        if (busy !== 1'b0 || capture_en !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_idle: busy %b cap %b, required 0 0", busy, capture_en);
        end
        drain_check("stop");
    endtask

    task automatic test_short_frame_wrap();
        pulse_start(16'd0);
        push_exp(KStart, 0, 0);
        vsync();
        line();
        line();
        push_exp(KErr, 0, 0);
        vsync();
        vectors++;
        if (capture_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL short_rearm: cap %b busy %b, required 0 1", capture_en, busy);
        end
        for (int f = 0; f < 5; f++) begin
            push_exp(KStart, f % 4, f);
            vsync();
            for (int l = 0; l < 4; l++) line();
            push_exp(KDone, (f + 1) % 4, f + 1);
            dma_pulse();
        end
        vectors++;
        if (buf_idx !== 2'd1 || frame_cnt !== 32'd5 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_final: idx %0d cnt %0d busy %b, required 1 5 1", buf_idx, frame_cnt, busy);
        end
        push_exp(KSeq, 1, 5);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        drain_check("wrap");
    endtask

    task automatic test_timeout();
        int n;
        pulse_start(16'd1);
        push_exp(KSeq, 0, 0);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        vectors++;
        if (n !== 101 || timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_fire: idle after %0d cycles timeout %b, required 101 1", n, timeout);
        end
        tick(3);
        pulse_start(16'd1);
        vectors++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_clear: timeout %b busy %b, required 0 1", timeout, busy);
        end
        push_exp(KSeq, 0, 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        drain_check("timeout");
    endtask

    task automatic test_priorities();
        frame_num = 16'd1;
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_stop_same_cycle: busy %b, required 0", busy);
        end
        pulse_start(16'd1);
        dma_done = 1'b1;
        tick(1);
        dma_done = 1'b0;
        tick(1);
        vectors++;
        if (frame_done !== 1'b0 || frame_cnt !== 32'd0 || buf_idx !== 2'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL dma_outside_wait: cnt %0d idx %0d busy %b, required 0 0 1", frame_cnt, buf_idx, busy);
        end
        push_exp(KSeq, 0, 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        drain_check("prio");
    endtask

    task automatic test_async_reset();
        pulse_start(16'd0);
        buf_ready = 1'b0;
        vsync();
        buf_ready = 1'b1;
        push_exp(KStart, 0, 0);
        vsync();
        for (int l = 0; l < 4; l++) line();
        push_exp(KDone, 1, 1);
        dma_pulse();
        push_exp(KStart, 1, 1);
        vsync();
        de = 1'b1;
        tick(1);
        vectors++;
        if (capture_en !== 1'b1 || drop_cnt !== 16'd1 || frame_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL areset_pre: cap %b drop %0d cnt %0d, required 1 1 1", capture_en, drop_cnt, frame_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (capture_en !== 1'b0 || busy !== 1'b0 || frame_cnt !== 32'd0
            || drop_cnt !== 16'd0 || buf_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL areset_now: cap %b busy %b cnt %0d drop %0d idx %0d, required all 0",
                     capture_en, busy, frame_cnt, drop_cnt, buf_idx);
        end
        de = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        drain_check("areset");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        vs        = 1'b0;
        de        = 1'b0;
        buf_ready = 1'b1;
        dma_done  = 1'b0;
        frame_num = 16'd0;
        tick(3);
        test_reset();
        rst_n = 1'b1;
        tick(2);
        test_reset();
        test_single_frame();
        test_starvation();
        test_deferred_stop();
        test_short_frame_wrap();
        test_timeout();
        test_priorities();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_frame_sched.md
# video_frame_sched

Frame-level capture scheduler for the PCIe video-to-DMA path. It takes host start/stop commands and a frame count, arms on a frame boundary only when a DMA buffer is free, and drives the capture gate for the video gating stage. It rotates buffer indices across the DMA ring, waits for the per-frame DMA-done handshake, and reports drops, short frames and video/DMA timeouts.

## Interface
- VIDEO_CLK_FREQ, 148500000, video clock in Hz; timeout = VIDEO_CLK_FREQ cycles (1 s)
- IMG_HEIGHT, 1080, active lines per frame
- NUM_BUF, 4, DMA ring depth (power of 2, 2..16); BUF_W = clog2(NUM_BUF)
- Reset is asynchronous, active-low, on a single clock domain.
- i_video_clk  in  1  sole clock
- i_rst_n  in  1  async active-low reset
- i_start  in  1  1-cycle start pulse
- i_stop  in  1  1-cycle stop pulse
- i_frame_num  in  16  frames to capture; 0 means continuous
- i_video_vs  in  1  raw vsync, active high
- i_video_de  in  1  raw data enable
- i_buf_ready  in  1  DMA has a free buffer at o_buf_idx
- i_dma_done  in  1  1-cycle pulse: current frame fully written
- o_capture_en  out  1  gate enable to the video gating stage
- o_frame_start  out  1  pulse: capture of a frame begins
- o_frame_done  out  1  pulse: frame committed (DMA done accepted)
- o_seq_done  out  1  pulse: sequence finished, returning to IDLE
- o_busy  out  1  state != IDLE
- o_buf_idx  out  BUF_W  buffer targeted by the current or next frame
- o_frame_cnt  out  32  frames committed since the last start
- o_drop_cnt  out  16  saturating count of frames skipped because no buffer was ready
- o_frame_err  out  1  pulse: short frame aborted
- o_timeout  out  1  sticky; cleared by an accepted i_start

## Operation
- vs_rise = i_video_vs & ~vs_d0, where vs_d0 is i_video_vs registered. line_end = de_d0 & ~i_video_de.
- States: IDLE, ARM, CAPTURE, WAIT_DONE.
- IDLE
  - i_start (without i_stop) -> ARM.
  - On that transition: load frames_left = i_frame_num, cont = (i_frame_num == 0); clear o_frame_cnt, o_drop_cnt, o_timeout, stop_pend, and o_buf_idx to 0.
- ARM
  - vs_rise & i_buf_ready -> CAPTURE; pulse o_frame_start; clear line_cnt.
  - vs_rise & ~i_buf_ready -> stay in ARM; o_drop_cnt += 1, saturating at 0xFFFF.
  - i_stop -> IDLE immediately; pulse o_seq_done.
- CAPTURE
  - o_capture_en = 1. line_cnt (11 bits min, sized to IMG_HEIGHT) increments on line_end.
  - line_end with line_cnt == IMG_HEIGHT-1 -> WAIT_DONE.
  - vs_rise before that -> ARM; pulse o_frame_err. No commit, no buffer advance. The current vs_rise is not reused: re-arm waits for the next vs_rise.
  - i_stop sets stop_pend; the frame completes normally.
- WAIT_DONE
  - o_capture_en = 0. i_stop sets stop_pend.
  - i_dma_done: pulse o_frame_done; o_frame_cnt += 1; o_buf_idx = (o_buf_idx+1) mod NUM_BUF.
  - If ~cont, frames_left -= 1.
  - If stop_pend, or (~cont & frames_left == 1 before decrement) -> IDLE and pulse o_seq_done. Otherwise -> ARM.
- Timeout
  - dly_cnt clears on vs_rise, on i_video_de, on i_dma_done, and on any state change. Otherwise it counts up, saturating at TIME_OUT.
  - dly_cnt == TIME_OUT in ARM, CAPTURE or WAIT_DONE -> IDLE; set o_timeout; pulse o_seq_done.
- Priorities
  - In IDLE, i_start and i_stop in the same cycle: stop wins, start is ignored.
  - i_start while busy is ignored.
  - i_dma_done outside WAIT_DONE is ignored.
  - Timeout outranks every other transition in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Every output is registered; each pulse is exactly 1 cycle.
- o_capture_en rises 1 cycle after the vs_rise that enters CAPTURE. This gives the gating stage the vs-high cycles of the frame.
- o_capture_en falls 1 cycle after the final line_end.
- o_frame_start is coincident with o_capture_en rising.
- o_frame_done, o_buf_idx update and o_frame_cnt update all occur 1 cycle after i_dma_done.
- The transition into ARM after a commit is visible the next cycle. A vs_rise in that same cycle is missed, so the bench must keep ≥2 cycles between i_dma_done and vs.
- Reset mid-frame: o_capture_en drops asynchronously and immediately.

## Test plan
- **Single frame.** i_frame_num=1, i_buf_ready=1, IMG_HEIGHT=4 (test override); one vs, 4 lines, then i_dma_done. Expect one o_frame_start, o_capture_en high over 4 lines, o_frame_done, then o_seq_done; o_frame_cnt=1, o_buf_idx=1, o_busy=0.
- **Buffer starvation.** i_buf_ready=0 for 3 vs edges, then 1. Expect o_drop_cnt=3 and capture on the 4th frame.
- **Deferred stop.** i_stop mid-CAPTURE in continuous mode. Expect the frame to complete; after i_dma_done, o_frame_done then o_seq_done, with no further o_frame_start.
- **Short frame and ring wrap.** vs_rise after 2 of 4 lines: expect o_frame_err, no o_frame_done, capture resumes on the next vs. Separately, continuous mode for 5 frames with NUM_BUF=4: o_buf_idx sequence 0,1,2,3,0,1.
- **Timeout.** VIDEO_CLK_FREQ=100 (test override); armed with vs held low for 100 cycles. Expect IDLE, o_timeout=1 and o_seq_done. A subsequent i_start clears o_timeout.
- **Async reset.** Assert i_rst_n low mid-CAPTURE between clock edges. Expect o_capture_en=0 without waiting for an edge; all counters 0.
